// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates a compare condition, registers the
// resolved direction with its prediction, and counts resolved and
// mispredicted branches at the output handshake.
// Optional feature macro: BRANCH_UNIT_PREDICT_EN compiles in a table of
// 2-bit saturating counters that supplies the prediction. Without it the
// prediction is constant 0, so every taken branch counts as mispredicted.
module branch_unit #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_pred,
  output logic             out_mispred,
  output logic             out_illegal,
  output logic [IDX_W-1:0] out_idx,
  output logic [15:0]      br_cnt,
  output logic [15:0]      mp_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  // Resolve a condition code; returns {illegal, taken}.
  function automatic logic [1:0] resolve(input logic [2:0]       op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic                    t;
    logic                    ill;
    sa  = $signed(a);
    sb  = $signed(b);
    t   = 1'b0;
    ill = 1'b0;
    case (op)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b010:  t = (a < b);
      3'b011:  t = (a <= b);
      3'b100:  t = (sa < sb);
      3'b101:  t = (sa >= sb);
      3'b110:  t = (a >= b);
      default: begin
        t   = 1'b0;
        ill = 1'b1;
      end
    endcase
    return {ill, t};
  endfunction

  // 16-bit event counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // 2-bit predictor counter step, saturating at 00 and 11.
  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up && c != 2'b11)
      r = c + 2'b01;
    else if (!up && c != 2'b00)
      r = c - 2'b01;
    return r;
  endfunction

  logic             vld_p1;
  logic             taken_p1;
  logic             pred_p1;
  logic             ill_p1;
  logic [IDX_W-1:0] idx_p1;
  logic [15:0]      br_q;
  logic [15:0]      mp_q;
  logic             accept;
  logic             fire;
  logic             pred_rd;
  logic [1:0]       res_p0;

  assign in_ready = !flush && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;
  assign fire     = vld_p1 && out_ready && !flush;
  assign res_p0   = resolve(in_op, in_a, in_b);

`ifdef BRANCH_UNIT_PREDICT_EN
  logic [1:0] tbl [DEPTH];

  // Prediction is the counter MSB, read before any same-cycle training write.
  assign pred_rd = tbl[in_idx][1];

  // Train the entry of each result as it leaves the unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= 2'b01;
    end else if (fire) begin
      tbl[idx_p1] <= sat_ctr(tbl[idx_p1], taken_p1);
    end
  end
`else
  assign pred_rd = 1'b0;
`endif

  // ---- stage p0 -> p1: single output register with valid/ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      taken_p1 <= 1'b0;
      pred_p1  <= 1'b0;
      ill_p1   <= 1'b0;
      idx_p1   <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      taken_p1 <= res_p0[0];
      ill_p1   <= res_p0[1];
      pred_p1  <= pred_rd;
      idx_p1   <= in_idx;
    end else if (fire) begin
      vld_p1 <= 1'b0;
    end
  end

  // Count every result that leaves the unit; flushed results never fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q <= 16'd0;
      mp_q <= 16'd0;
    end else if (fire) begin
      br_q <= sat_inc16(br_q);
      if (taken_p1 ^ pred_p1)
        mp_q <= sat_inc16(mp_q);
    end
  end

  assign out_valid   = vld_p1;
  assign out_taken   = taken_p1;
  assign out_pred    = pred_p1;
  assign out_mispred = taken_p1 ^ pred_p1;
  assign out_illegal = ill_p1;
  assign out_idx     = idx_p1;
  assign br_cnt      = br_q;
  assign mp_cnt      = mp_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: the driver pushes hand-computed
// expectations as requests are accepted, a monitor pops them as results fire.
module tb_branch_unit;
  localparam int W  = 32;
  localparam int IW = 4;
`ifdef BRANCH_UNIT_PREDICT_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'd0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [IW-1:0] in_idx = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_taken, out_pred, out_mispred, out_illegal;
  logic [IW-1:0] out_idx;
  logic [15:0]   br_cnt, mp_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          taken;
    logic          pred;
    logic          ill;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t        q[$];
  logic [1:0]  mtbl [16];
  logic [15:0] mbr = 16'd0;
  logic [15:0] mmp = 16'd0;
  logic        last_pred = 1'b0;
  logic        last_mispred = 1'b0;
  logic [15:0] base;

  branch_unit #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_idx(in_idx), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_pred(out_pred), .out_mispred(out_mispred), .out_illegal(out_illegal),
    .out_idx(out_idx), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mtbl[i] = 2'b01;
    mbr = 16'd0;
    mmp = 16'd0;
    q.delete();
  endtask

  function automatic logic model_pred(input logic [IW-1:0] i);
    return PE & mtbl[i][1];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request; called 1 time unit after a rising edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [IW-1:0] idx, input logic t, input logic ill);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_idx = idx;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end else begin
      e.taken = t; e.pred = model_pred(idx); e.ill = ill; e.idx = idx;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: pop on fire, drop on flush, train the model after the edge.
  initial begin
    exp_t e;
    bit   pend;
    forever begin
      @(negedge clk);
      pend = 1'b0;
      if (rst_n && out_valid && flush) begin
        if (q.size() > 0) void'(q.pop_front());
      end else if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=out_valid required=empty");
        end else begin
          e = q.pop_front();
          chk("out_taken", {31'd0, out_taken}, {31'd0, e.taken});
          chk("out_pred", {31'd0, out_pred}, {31'd0, e.pred});
          chk("out_mispred", {31'd0, out_mispred}, {31'd0, e.taken ^ e.pred});
          chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
          chk("out_idx", {28'd0, out_idx}, {28'd0, e.idx});
          last_pred = out_pred;
          last_mispred = out_mispred;
          pend = 1'b1;
        end
      end
      @(posedge clk);
      if (pend && rst_n) begin
        if (mbr != 16'hFFFF) mbr = mbr + 16'd1;
        if ((e.taken ^ e.pred) && mmp != 16'hFFFF) mmp = mmp + 16'd1;
        if (e.taken && mtbl[e.idx] != 2'b11) mtbl[e.idx] = mtbl[e.idx] + 2'b01;
        else if (!e.taken && mtbl[e.idx] != 2'b00) mtbl[e.idx] = mtbl[e.idx] - 2'b01;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_taken", {31'd0, out_taken}, 32'd0);
    chk("rst_out_idx", {28'd0, out_idx}, 32'd0);
    chk("rst_br_cnt", {16'd0, br_cnt}, 32'd0);
    chk("rst_mp_cnt", {16'd0, mp_cnt}, 32'd0);
    #21 rst_n = 1'b1;
    tick(1);

    // Unsigned versus signed view of the same operands.
    issue(3'b010, 32'hFFFF_FFFF, 32'h1, 4'd1, 1'b0, 1'b0);
    chk("ltu_latency_valid", {31'd0, out_valid}, 32'd1);
    chk("ltu_taken", {31'd0, out_taken}, 32'd0);
    issue(3'b100, 32'hFFFF_FFFF, 32'h1, 4'd2, 1'b1, 1'b0);
    chk("lt_taken", {31'd0, out_taken}, 32'd1);
    issue(3'b000, 32'h7, 32'h7, 4'd0, 1'b1, 1'b0);
    issue(3'b001, 32'h7, 32'h7, 4'd0, 1'b0, 1'b0);
    issue(3'b011, 32'h3, 32'h3, 4'd1, 1'b1, 1'b0);
    issue(3'b101, 32'hFFFF_FFFF, 32'h0, 4'd2, 1'b0, 1'b0);
    issue(3'b110, 32'hFFFF_FFFF, 32'h0, 4'd4, 1'b1, 1'b0);
    issue(3'b100, 32'h8000_0000, 32'h0, 4'd6, 1'b1, 1'b0);
    issue(3'b010, 32'h8000_0000, 32'h0, 4'd6, 1'b0, 1'b0);
    issue(3'b000, 32'h1234_5678, 32'h9234_5678, 4'd8, 1'b0, 1'b0);
    tick(2);
    chk("burst_br_cnt", {16'd0, br_cnt}, {16'd0, mbr});
    chk("burst_br_hand", {16'd0, br_cnt}, 32'd10);
    chk("burst_mp_cnt", {16'd0, mp_cnt}, {16'd0, mmp});

    // Reserved op.
    base = mbr;
    issue(3'b111, 32'd5, 32'd5, 4'd4, 1'b0, 1'b1);
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    tick(2);
    chk("ill_br_inc", {16'd0, br_cnt}, {16'd0, base + 16'd1});

    // Backpressure hold, then fire and accept together.
    out_ready = 1'b0;
    issue(3'b000, 32'd1, 32'd1, 4'd5, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_taken", {31'd0, out_taken}, 32'd1);
      chk("bp_idx", {28'd0, out_idx}, 32'd5);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(3'b001, 32'd1, 32'd2, 4'd6, 1'b1, 1'b0);
    chk("bp_valid_stays", {31'd0, out_valid}, 32'd1);
    chk("bp_new_idx", {28'd0, out_idx}, 32'd6);
    tick(2);

    // Flush of a held mispredicted result.
    base = mbr;
    out_ready = 1'b0;
    issue(3'b000, 32'd4, 32'd4, 4'd7, 1'b1, 1'b0);
    chk("fl_mispred", {31'd0, out_mispred}, 32'd1);
    flush = 1'b1;
    in_valid = 1'b1; in_op = 3'b000; in_idx = 4'd9;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid_clr", {31'd0, out_valid}, 32'd0);
    tick(1);
    chk("fl_br_cnt", {16'd0, br_cnt}, {16'd0, base});
    chk("fl_mp_cnt", {16'd0, mp_cnt}, {16'd0, mmp});

    // Predictor training at idx 3.
    issue(3'b000, 32'd9, 32'd9, 4'd3, 1'b1, 1'b0);
    tick(1);
    chk("train_pred0", {31'd0, last_pred}, 32'd0);
    issue(3'b000, 32'd9, 32'd9, 4'd3, 1'b1, 1'b0);
    tick(1);
    chk("train_pred1", {31'd0, last_pred}, {31'd0, PE});
    issue(3'b000, 32'd9, 32'd9, 4'd3, 1'b1, 1'b0);
    tick(1);
    chk("train_pred2", {31'd0, last_pred}, {31'd0, PE});
    issue(3'b001, 32'd9, 32'd9, 4'd3, 1'b0, 1'b0);
    tick(1);
    chk("train_nt_pred", {31'd0, last_pred}, {31'd0, PE});
    chk("train_nt_mispred", {31'd0, last_mispred}, {31'd0, PE});
    chk("train_mp_cnt", {16'd0, mp_cnt}, {16'd0, mmp});

    // Counter saturation from a preloaded value.
    force dut.br_q = 16'hFFFB;
    #1;
    release dut.br_q;
    mbr = 16'hFFFB;
    tick(1);
    for (int k = 0; k < 3; k++)
      issue(3'b000, 32'd0, 32'd0, 4'd10, 1'b1, 1'b0);
    tick(2);
    chk("sat_fffe", {16'd0, br_cnt}, 32'h0000_FFFE);
    for (int k = 0; k < 3; k++)
      issue(3'b001, 32'd0, 32'd0, 4'd10, 1'b0, 1'b0);
    tick(2);
    chk("sat_ffff", {16'd0, br_cnt}, 32'h0000_FFFF);
    chk("sat_model", {16'd0, br_cnt}, {16'd0, mbr});

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    issue(3'b000, 32'd1, 32'd1, 4'd8, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_taken", {31'd0, out_taken}, 32'd0);
    chk("arst_idx", {28'd0, out_idx}, 32'd0);
    chk("arst_br_cnt", {16'd0, br_cnt}, 32'd0);
    chk("arst_mp_cnt", {16'd0, mp_cnt}, 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    issue(3'b000, 32'd2, 32'd2, 4'd9, 1'b1, 1'b0);
    chk("post_rst_accept", {31'd0, out_valid}, 32'd1);
    tick(2);
    chk("post_rst_br_cnt", {16'd0, br_cnt}, 32'd1);

    tick(2);
    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
